// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 bit mux with registered output
// Optional hold limit under contention: define MUX_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] input_lines,
  output logic [3:0] grant,
  output logic [1:0] select_lines,
  output logic       busy,
  output logic       out,
  output logic       out_valid
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
    $error("mux4_rr_arbiter: MAX_HOLD must be 1..255 and below 2**CNT_W");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx, sel_nx, pick;
  logic [3:0]       grant_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic             handoff;

  assign busy = (state == GRANT);

  // First set request at or after ptr; highest offset is overwritten by lower ones.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    sel_nx   = select_lines;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    handoff  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) handoff = 1'b1;
      end
      GRANT: begin
        if (!req[select_lines]) begin
          if (|req) begin
            handoff = 1'b1;
          end else begin
            state_nx = IDLE;
            grant_nx = 4'b0000;
          end
        end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
          if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            if (|(req & ~grant)) handoff = 1'b1;
            else                 hold_nx = '0;
          end else if (hold_cnt != '1) begin
            hold_nx = hold_cnt + 1'b1;
          end
`else
          if (hold_cnt != '1) hold_nx = hold_cnt + 1'b1;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
    if (handoff) begin
      state_nx = GRANT;
      grant_nx = 4'b0001 << pick;
      sel_nx   = pick;
      ptr_nx   = pick + 2'd1;
      hold_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= 4'b0000;
      select_lines <= 2'b00;
      ptr          <= 2'd0;
      hold_cnt     <= '0;
      out          <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      state        <= state_nx;
      grant        <= grant_nx;
      select_lines <= sel_nx;
      ptr          <= ptr_nx;
      hold_cnt     <= hold_nx;
      out          <= busy ? input_lines[select_lines] : 1'b0;
      out_valid    <= busy;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter with an owner-level reference model
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] input_lines = 4'b0000;
  logic [3:0] grant;
  logic [1:0] select_lines;
  logic       busy, out, out_valid;

  int total = 0;
  int bad = 0;

  int   m_owner = -1;
  int   m_ptr = 0;
  int   m_hold = 0;
  int   m_sel = 0;
  int   m_out = 0;
  int   m_ov = 0;
  int   order[5] = '{0, 1, 2, 3, 0};
  int   exp_g;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .input_lines(input_lines),
    .grant(grant), .select_lines(select_lines), .busy(busy),
    .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_from(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic take(int who);
    m_owner = who;
    m_sel   = who;
    m_ptr   = (who + 1) % 4;
    m_hold  = 0;
  endtask

  // Reference: owner index (-1 idle), rotating pointer, hold count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_out = 0; m_ov = 0;
    end else begin
      m_out = (m_owner >= 0) ? int'(input_lines[m_sel]) : 0;
      m_ov  = (m_owner >= 0) ? 1 : 0;
      if (m_owner < 0) begin
        if (req != 0) take(pick_from(req, m_ptr));
      end else if (!req[m_owner]) begin
        if (req != 0) take(pick_from(req, m_ptr));
        else m_owner = -1;
      end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
        if (m_hold == MAX_HOLD - 1) begin
          if ((req & ~(4'b0001 << m_owner)) != 0) take(pick_from(req, m_ptr));
          else m_hold = 0;
        end else if (m_hold < 255) m_hold++;
`else
        if (m_hold < 255) m_hold++;
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("select_lines", select_lines, m_sel);
    chk("busy", busy, (m_owner >= 0) ? 1 : 0);
    chk("out", out, m_out);
    chk("out_valid", out_valid, m_ov);
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("lit_idle_grant", grant, 0);
      chk("lit_idle_busy", busy, 0);
      chk("lit_idle_valid", out_valid, 0);
    end

    #1 input_lines = 4'b0101;
    req = 4'b0100;
    @(negedge clk);
    chk("lit_single_grant", grant, 4);
    chk("lit_single_sel", select_lines, 2);
    chk("lit_single_valid0", out_valid, 0);
    @(negedge clk);
    chk("lit_single_out", out, 1);
    chk("lit_single_valid1", out_valid, 1);
    @(negedge clk);
    #1 req = 4'b0000;
    @(negedge clk);
    chk("lit_drop_busy", busy, 0);
    chk("lit_drop_valid_lag", out_valid, 1);
    @(negedge clk);
    chk("lit_drop_valid", out_valid, 0);

    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lit_rr_grant", grant, 1 << order[i]);
      chk("lit_rr_busy", busy, 1);
      #1 req = 4'b1111 ^ (4'b0001 << order[i]);
    end

    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      exp_g = ((k / MAX_HOLD) % 2 == 1) ? 2 : 1;
`else
      exp_g = 1;
`endif
      chk("lit_hold_grant", grant, exp_g);
    end

    do_reset();
    input_lines = 4'b0010;
    req = 4'b0010;
    repeat (2) @(negedge clk);
    chk("lit_async_pre_grant", grant, 2);
    chk("lit_async_pre_out", out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_grant", grant, 0);
    chk("lit_async_sel", select_lines, 0);
    chk("lit_async_busy", busy, 0);
    chk("lit_async_out", out, 0);
    chk("lit_async_valid", out_valid, 0);
    #1 rst_n = 1'b1;
    req = 4'b1010;
    @(negedge clk);
    chk("lit_async_after", grant, 2);

    repeat (400) begin
      @(negedge clk);
      #1 req = 4'($urandom_range(0, 15));
      input_lines = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
